// File: rtl/ysyx_2022040010_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU data-SRAM arbiter.
// Also holds helpers that size the request payload bus.
package ysyx_2022040010_mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OWN_LSU = 1'b0;
  localparam logic OWN_IFU = 1'b1;

  localparam int ADDR_W_DEF     = 64;
  localparam int DATA_W_DEF     = 64;
  localparam int STARVE_MAX_DEF = 4;

  // Width of the request payload {addr, we, wdata, wmask}.
  function automatic int req_bus_w(input int addr_w, input int data_w);
    return addr_w + 1 + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/ysyx_2022040010_mem_arbiter_if.sv
// Requester and downstream memory handshake bundle for the data-SRAM arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline/memory.
interface ysyx_2022040010_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_W-1:0]     ifu_req_addr;
  logic                  ifu_resp_valid;
  logic [DATA_W-1:0]     ifu_resp_rdata;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_W-1:0]     lsu_req_addr;
  logic                  lsu_req_we;
  logic [DATA_W-1:0]     lsu_req_wdata;
  logic [DATA_W/8-1:0]   lsu_req_wmask;
  logic                  lsu_resp_valid;
  logic [DATA_W-1:0]     lsu_resp_rdata;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_req_addr;
  logic                  mem_req_we;
  logic [DATA_W-1:0]     mem_req_wdata;
  logic [DATA_W/8-1:0]   mem_req_wmask;
  logic                  mem_resp_valid;
  logic [DATA_W-1:0]     mem_resp_rdata;

  modport slave (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
    input  lsu_req_valid, lsu_req_addr, lsu_req_we, lsu_req_wdata, lsu_req_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport master (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
    output lsu_req_valid, lsu_req_addr, lsu_req_we, lsu_req_wdata, lsu_req_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/ysyx_2022040010_arb_prio.sv
// Fixed-priority LSU-over-IFU grant with a saturating starvation counter.
// Grants are combinational; only the counter is registered.
module ysyx_2022040010_arb_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic ifu_valid,
  input  logic lsu_valid,
  output logic grant_ifu,
  output logic grant_lsu
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved   = (starve_cnt == CNT_W'(STARVE_MAX));
  assign grant_lsu = arb_en & lsu_valid & ~(ifu_valid & starved);
  assign grant_ifu = arb_en & ifu_valid & ~grant_lsu;

  // Only contested LSU wins count; any IFU win restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_ifu) begin
      starve_cnt <= '0;
    end else if (grant_lsu & ifu_valid & ~starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_2022040010_mem_arbiter.sv
// Shares the single data-SRAM port between IFU and LSU, one transaction at a time.
// The FSM latches the winner's payload, drives the memory request and routes the response.
module ysyx_2022040010_mem_arbiter
  import ysyx_2022040010_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  ysyx_2022040010_mem_arbiter_if.slave bus,
  output logic busy
);
  localparam int MASK_W = DATA_W / 8;
  localparam int REQ_W  = req_bus_w(ADDR_W, DATA_W);

  logic [1:0]        state;
  logic              owner;
  logic [REQ_W-1:0]  req_q;
  logic [REQ_W-1:0]  req_d;
  logic              grant_ifu;
  logic              grant_lsu;
  logic              ifu_resp_valid_q;
  logic              lsu_resp_valid_q;
  logic [DATA_W-1:0] ifu_resp_rdata_q;
  logic [DATA_W-1:0] lsu_resp_rdata_q;

  ysyx_2022040010_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (state == ST_IDLE),
    .ifu_valid (bus.ifu_req_valid),
    .lsu_valid (bus.lsu_req_valid),
    .grant_ifu (grant_ifu),
    .grant_lsu (grant_lsu)
  );

  // Fetches are read-only, so their write fields are forced to zero.
  always_comb begin
    if (grant_ifu) begin
      req_d = {bus.ifu_req_addr, 1'b0, {DATA_W{1'b0}}, {MASK_W{1'b0}}};
    end else begin
      req_d = {bus.lsu_req_addr, bus.lsu_req_we, bus.lsu_req_wdata, bus.lsu_req_wmask};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      owner            <= OWN_LSU;
      // NOTE: the payload is a handful of flops, not a RAM, so clearing it on reset is cheap and keeps the memory outputs at 0.
      req_q            <= '0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      ifu_resp_rdata_q <= '0;
      lsu_resp_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking everywhere here; the pulse defaults below are overridden later in the same block.
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_ifu | grant_lsu) begin
            req_q <= req_d;
            owner <= grant_ifu ? OWN_IFU : OWN_LSU;
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.mem_req_ready) state <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.mem_resp_valid) begin
            state <= ST_IDLE;
            if (owner == OWN_IFU) begin
              ifu_resp_valid_q <= 1'b1;
              ifu_resp_rdata_q <= bus.mem_resp_rdata;
            end else begin
              lsu_resp_valid_q <= 1'b1;
              lsu_resp_rdata_q <= bus.mem_resp_rdata;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ifu_req_ready  = grant_ifu;
  assign bus.lsu_req_ready  = grant_lsu;
  assign bus.ifu_resp_valid = ifu_resp_valid_q;
  assign bus.ifu_resp_rdata = ifu_resp_rdata_q;
  assign bus.lsu_resp_valid = lsu_resp_valid_q;
  assign bus.lsu_resp_rdata = lsu_resp_rdata_q;
  assign bus.mem_req_valid  = (state == ST_REQ);
  assign {bus.mem_req_addr, bus.mem_req_we, bus.mem_req_wdata, bus.mem_req_wmask} = req_q;
  assign busy               = (state != ST_IDLE);

endmodule
